// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl -- receive-side control for an asynchronous serial port.
// Synchronizes the raw line, finds the start edge, strobes a downstream
// LSB-first shift register at mid-bit, checks the stop bit and loads the
// received word with data_ready / framing_error / overrun_error status.
//
// Optional build macro RX_START_VERIFY_EN: when defined, the start bit is
// re-sampled at mid-bit (START_CHK state) so short line glitches are
// rejected. When undefined, START_CHK is absent and a start edge goes
// straight to RECEIVE with the same first-bit sampling point.

module rx_packet_ctrl #(
   parameter int CLKS_PER_BIT  = 10,
   parameter int NUM_DATA_BITS = 8
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     serial_in,
   input  logic                     data_read,
   input  logic [NUM_DATA_BITS:0]   sr_data,
   output logic                     serial_sync,
   output logic                     shift_enable,
   output logic [NUM_DATA_BITS-1:0] rx_data,
   output logic                     data_ready,
   output logic                     framing_error,
   output logic                     overrun_error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(NUM_DATA_BITS + 2);

   localparam logic [CNT_W-1:0] C_BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] C_BITS_TOTAL = BIT_W'(NUM_DATA_BITS + 1);
`ifdef RX_START_VERIFY_EN
   localparam logic [CNT_W-1:0] C_HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
`else
   localparam logic [CNT_W-1:0] C_HALF       = CNT_W'(CLKS_PER_BIT / 2);
`endif

`ifdef RX_START_VERIFY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START_CHK, S_RECEIVE, S_STOP_CHK, S_LOAD
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_RECEIVE, S_STOP_CHK, S_LOAD
   } state_t;
`endif

   logic                     r_sync1;
   logic                     r_sync2;
   logic                     r_prev;
   state_t                   r_state;
   logic [CNT_W-1:0]         r_clk_cnt;
   logic [BIT_W-1:0]         r_bit_cnt;
   logic                     r_shift_enable;
   logic [NUM_DATA_BITS-1:0] r_rx_data;
   logic                     r_data_ready;
   logic                     r_framing_error;
   logic                     r_overrun_error;
`ifndef RX_START_VERIFY_EN
   // Set on entry to RECEIVE: the first terminal count lands mid start bit
   // and must not strobe the shift register.
   logic                     r_skip_start;
`endif

   logic w_start_edge;

   assign w_start_edge  = r_prev & ~r_sync2;
   assign serial_sync   = r_sync2;
   assign shift_enable  = r_shift_enable;
   assign rx_data       = r_rx_data;
   assign data_ready    = r_data_ready;
   assign framing_error = r_framing_error;
   assign overrun_error = r_overrun_error;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   // NOTE: reset to 1 (line idle) so releasing reset never fakes a start edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         // NOTE: non-blocking so each flop takes the previous stage's old value.
         r_sync1 <= serial_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Frame FSM with registered strobe and status outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state         <= S_IDLE;
         r_clk_cnt       <= '0;
         r_bit_cnt       <= '0;
         r_shift_enable  <= 1'b0;
         r_rx_data       <= '0;
         r_data_ready    <= 1'b0;
         r_framing_error <= 1'b0;
         r_overrun_error <= 1'b0;
`ifndef RX_START_VERIFY_EN
         r_skip_start    <= 1'b0;
`endif
      end else begin
         r_shift_enable <= 1'b0;
         // Host acknowledge; the LOAD branch below overrides on a collision.
         if (data_read) begin
            r_data_ready    <= 1'b0;
            r_overrun_error <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start_edge) begin
                  r_framing_error <= 1'b0;
                  r_bit_cnt       <= '0;
`ifdef RX_START_VERIFY_EN
                  r_clk_cnt       <= '0;
                  r_state         <= S_START_CHK;
`else
                  r_clk_cnt       <= C_HALF;
                  r_skip_start    <= 1'b1;
                  r_state         <= S_RECEIVE;
`endif
               end
            end

`ifdef RX_START_VERIFY_EN
            S_START_CHK: begin
               if (r_clk_cnt == C_HALF_LAST) begin
                  r_clk_cnt <= '0;
                  r_state   <= r_sync2 ? S_IDLE : S_RECEIVE;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
`endif

            S_RECEIVE: begin
               if (r_bit_cnt == C_BITS_TOTAL) begin
                  r_state <= S_STOP_CHK;
               end else if (r_clk_cnt == C_BIT_LAST) begin
                  r_clk_cnt <= '0;
`ifdef RX_START_VERIFY_EN
                  r_shift_enable <= 1'b1;
                  r_bit_cnt      <= r_bit_cnt + BIT_W'(1);
`else
                  if (r_skip_start) begin
                     r_skip_start <= 1'b0;
                  end else begin
                     r_shift_enable <= 1'b1;
                     r_bit_cnt      <= r_bit_cnt + BIT_W'(1);
                  end
`endif
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end

            // The last strobe has been captured by the shift register here.
            S_STOP_CHK: begin
               if (!sr_data[NUM_DATA_BITS]) begin
                  r_framing_error <= 1'b1;
                  r_state         <= S_IDLE;
               end else begin
                  r_state <= S_LOAD;
               end
            end

            S_LOAD: begin
               r_rx_data       <= sr_data[NUM_DATA_BITS-1:0];
               r_data_ready    <= 1'b1;
               r_overrun_error <= r_data_ready & ~data_read;
               r_state         <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
